// File: rtl/dmem_sized_ctrl.sv
// dmem_sized_ctrl: byte-addressed 32-bit little-endian data memory with
// byte/half/word stores, sign/zero-extended loads and a configurable access
// latency behind a req/ready/done handshake.
// Optional feature macro: DMEM_MISALIGN_EN (misaligned half/word accesses
// are suppressed and flagged on err_o instead of being force-aligned).
module dmem_sized_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1,
    parameter int ADDR_W  = $clog2(DEPTH) + 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int IDX_W = ADDR_W - 2;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         mem_q [DEPTH];

    logic                access_s;
    logic                is_byte_s;
    logic                is_half_s;
    logic                misalign_s;
    logic [1:0]          off_s;
    logic [IDX_W-1:0]    widx_s;
    logic [31:0]         rword_s;
    logic [7:0]          rbyte_s;
    logic [15:0]         rhalf_s;
    logic [31:0]         load_s;
    logic [3:0]          wmask_s;
    logic [31:0]         wword_s;
    logic                mem_we_s;
    logic                unused_addr_s;

    // Address bits above the array size wrap away and are deliberately dropped.
    assign unused_addr_s = ^addr_i[31:ADDR_W];

    // Decode the captured request into lane offset, lane mask and load value.
    always_comb begin
        access_s  = (state_q == S_WAIT) && (cnt_q == 4'd0);
        is_byte_s = (size_q == 2'b00);
        is_half_s = (size_q == 2'b01);
`ifdef DMEM_MISALIGN_EN
        misalign_s = (is_half_s && addr_q[0]) ||
                     (!is_byte_s && !is_half_s && (addr_q[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        // Half/word accesses are forced to their natural alignment.
        if (is_byte_s) begin
            off_s = addr_q[1:0];
        end else if (is_half_s) begin
            off_s = {addr_q[1], 1'b0};
        end else begin
            off_s = 2'b00;
        end
        widx_s  = addr_q[ADDR_W-1:2];
        rword_s = mem_q[widx_s];
        rbyte_s = rword_s[8*off_s +: 8];
        rhalf_s = off_s[1] ? rword_s[31:16] : rword_s[15:0];
        if (is_byte_s) begin
            load_s  = {{24{~uns_q & rbyte_s[7]}}, rbyte_s};
            wmask_s = 4'b0001 << off_s;
            wword_s = {4{wdata_q[7:0]}};
        end else if (is_half_s) begin
            load_s  = {{16{~uns_q & rhalf_s[15]}}, rhalf_s};
            wmask_s = off_s[1] ? 4'b1100 : 4'b0011;
            wword_s = {2{wdata_q[15:0]}};
        end else begin
            load_s  = rword_s;
            wmask_s = 4'b1111;
            wword_s = wdata_q;
        end
        mem_we_s = access_s && we_q && !misalign_s;
    end

    // Handshake FSM: next state, request capture and output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    addr_d  = addr_i[ADDR_W-1:0];
                    wdata_d = wdata_i;
                    cnt_d   = 4'(LATENCY - 1);
                    ready_d = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    done_d  = 1'b1;
                    err_d   = misalign_s;
                    state_d = S_DONE;
                    if (!we_q && !misalign_s) begin
                        rdata_d = load_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array with per-byte-lane write enables; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_s[i]) begin
                    mem_q[widx_s][8*i +: 8] <= wword_s[8*i +: 8];
                end
            end
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// Directed self-checking bench for dmem_sized_ctrl (DEPTH=256, LATENCY=2).
module tb_dmem_sized_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        ready_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          dones;

    dmem_sized_ctrl #(.DEPTH(256), .LATENCY(2)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; samples on falling edges.
    task automatic op(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdo, output logic ero, output int lato);
        lato = -1;
        rdo  = 32'd0;
        ero  = 1'b0;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns;
        addr_i = addr; wdata_i = wdata;
        @(negedge clk_i);
        req_i = 1'b0; wdata_i = ~wdata; addr_i = ~addr;
        for (int k = 0; k < 20; k++) begin
            if (done_o) begin
                lato = k;
                rdo  = rdata_o;
                ero  = err_o;
                break;
            end
            check_val("ready_busy", {31'd0, ready_o}, 32'd0);
            @(negedge clk_i);
        end
        check_val("latency", lato, 32'd2);
        @(negedge clk_i);
        check_val("ready_back", {31'd0, ready_o}, 32'd1);
        check_val("done_clear", {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        check_val("rst_ready", {31'd0, ready_o}, 32'd1);
        check_val("rst_done",  {31'd0, done_o},  32'd0);
        check_val("rst_rdata", rdata_o, 32'd0);
        check_val("rst_err",   {31'd0, err_o},   32'd0);
        rst_i = 1'b1;

        // Word load at 0x00: timing checked inside op
        op(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'd0, rd, er, lat);

        // Word store then byte store then word load
        op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, rd, er, lat);
        op(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, rd, er, lat);
        op(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, lat);
        check_val("byte_merge", rd, 32'h11AA_3344);
        check_val("err_aligned", {31'd0, er}, 32'd0);
        // Stores leave rdata_o alone
        op(1'b1, 2'b10, 1'b0, 32'h14, 32'h0000_0000, rd, er, lat);
        check_val("store_keeps_rdata", rdata_o, 32'h11AA_3344);
        op(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_BEEF, rd, er, lat);
        op(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, rd, er, lat);
        check_val("half_store", rd, 32'hBEEF_0000);

        // Extension on loads
        op(1'b1, 2'b10, 1'b0, 32'h20, 32'h80F0_7F85, rd, er, lat);
        op(1'b0, 2'b00, 1'b0, 32'h20, 32'd0, rd, er, lat);
        check_val("lb_s", rd, 32'hFFFF_FF85);
        op(1'b0, 2'b00, 1'b1, 32'h20, 32'd0, rd, er, lat);
        check_val("lb_u", rd, 32'h0000_0085);
        op(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, rd, er, lat);
        check_val("lh_s", rd, 32'hFFFF_80F0);
        op(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, rd, er, lat);
        check_val("lh_u", rd, 32'h0000_80F0);
        op(1'b0, 2'b00, 1'b0, 32'h21, 32'd0, rd, er, lat);
        check_val("lb_s_pos", rd, 32'h0000_007F);
        op(1'b0, 2'b01, 1'b0, 32'h20, 32'd0, rd, er, lat);
        check_val("lh_s_pos", rd, 32'h0000_7F85);

        // Wrap store with a req pulse during WAIT
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; unsigned_i = 1'b0;
        addr_i = 32'h400; wdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        we_i = 1'b1; addr_i = 32'h0; wdata_i = 32'h0BAD_0BAD;
        @(negedge clk_i);
        req_i = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (done_o) dones++;
            @(negedge clk_i);
        end
        check_val("one_done", dones, 32'd1);
        op(1'b0, 2'b10, 1'b0, 32'h000, 32'd0, rd, er, lat);
        check_val("wrap", rd, 32'hDEAD_BEEF);

        // Reset in the middle of a store
        op(1'b1, 2'b10, 1'b0, 32'h30, 32'h0102_0304, rd, er, lat);
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; addr_i = 32'h30; wdata_i = 32'hCAFE_BABE;
        @(negedge clk_i);
        req_i = 1'b0;
        rst_i = 1'b0;
        #1;
        check_val("rst_mid_ready", {31'd0, ready_o}, 32'd1);
        dones = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (done_o) dones++;
            @(negedge clk_i);
        end
        check_val("rst_mid_nodone", dones, 32'd0);
        check_val("rst_mid_ready2", {31'd0, ready_o}, 32'd1);
        op(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, rd, er, lat);
        check_val("rst_mid_nocommit", rd, 32'h0102_0304);

        // Misaligned word store
        op(1'b1, 2'b10, 1'b0, 32'h40, 32'h5555_5555, rd, er, lat);
        op(1'b1, 2'b10, 1'b0, 32'h41, 32'h1234_5678, rd, er, lat);
`ifdef DMEM_MISALIGN_EN
        check_val("misalign_err", {31'd0, er}, 32'd1);
        op(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, rd, er, lat);
        check_val("misalign_nowrite", rd, 32'h5555_5555);
`else
        check_val("misalign_err", {31'd0, er}, 32'd0);
        op(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, rd, er, lat);
        check_val("misalign_aligned", rd, 32'h1234_5678);
`endif
        check_val("err_low_after", {31'd0, err_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
